uart_rx_core: RTL and testbench
===============================

// Module: uart_rx_core
// PURPOSE
//  UART receive datapath: consumes the serial rx line and delivers parallel words with error status.
//  Runtime config arrives as the brr_valid/clk_per_bit and ctrl_valid/parity_en strobes, not through APB.
//  The output holding register is drained by the APB-side RX FIFO through a valid/ready handshake.
// PARAMETERS
//  DATA_W      8        data bits per frame, legal range 5..9, sent LSB first
//  DEFAULT_CPB 16'd868  clk_per_bit after reset (100 MHz clock, 115200 baud)
//  PARITY_ODD  0        0 = even parity, 1 = odd parity (used only when parity_en = 1)
// PORTS
//  clk          in   1       system clock
//  rst          in   1       synchronous reset, active-high
//  rx           in   1       asynchronous serial input, idle high
//  brr_valid    in   1       1-cycle strobe: capture clk_per_bit
//  clk_per_bit  in   16      clocks per bit; values < 4 are clamped to 4
//  ctrl_valid   in   1       1-cycle strobe: capture parity_en
//  parity_en    in   1       1 = one parity bit follows the data bits
//  rx_data      out  DATA_W  received word
//  parity_err   out  1       parity mismatch for the word in rx_data
//  frame_err    out  1       stop bit sampled low for the word in rx_data
//  rx_valid     out  1       rx_data / parity_err / frame_err valid
//  rx_ready     in   1       consumer accepts the word when rx_valid && rx_ready
//  overrun      out  1       1-cycle pulse: a completed frame was dropped
//  rx_busy      out  1       FSM not in IDLE
// BEHAVIOUR
//  Reset: rx_data = 0, all status outputs = 0, config = DEFAULT_CPB / parity off.
//   The synchronizer and its edge-detect delay reset to 1. FSM -> IDLE, counters = 0.
//  Sync: rx passes through a 2-flop synchronizer to give rx_s. rx_s_d is rx_s delayed 1 cycle.
//   Only rx_s is ever sampled.
//  Config: cfg_cpb and cfg_par update on their strobes in any state.
//   At start-edge detect the FSM copies them into cpb_act and par_act, used for the whole frame.
//   A change during a frame therefore takes effect only on the next frame.
//  Bit counter cnt counts down; a sample is taken in the cycle cnt == 0.
//   After each sample cnt reloads with cpb_act - 1.
//  FSM:
//   IDLE   : on rx_s_d == 1 && rx_s == 0, load cnt = cpb_act >> 1 and go to START.
//            A line held low never retriggers.
//   START  : at sample, rx_s == 1 means a false start -> IDLE, no output.
//            Otherwise bit_idx = 0 -> DATA.
//   DATA   : at sample, shift rx_s in at the MSB of a shift-right register and increment bit_idx.
//            After DATA_W samples go to PARITY if par_act, else to STOP.
//   PARITY : at sample, perr = (^shift ^ rx_s ^ PARITY_ODD) -> STOP.
//   STOP   : at sample, commit the word with ferr = ~rx_s -> IDLE.
//            IDLE is entered at the middle of the stop bit.
//  Commit: registered at the commit edge, so rx_valid rises 1 cycle after the stop sample cycle.
//   Latency from the rx line edge adds 2 cycles of synchronizer delay.
//  Handshake: rx_valid stays 1 until it is accepted; rx_data and status are stable while valid.
//   Commit with rx_valid == 0, or together with rx_ready == 1 in that cycle:
//    load the new word, rx_valid = 1, no overrun.
//   Commit while rx_valid == 1 and rx_ready == 0:
//    keep the old word, drop the new one, pulse overrun.
//  parity_err is 0 whenever par_act == 0.
//  rst mid-frame aborts the frame, clears any held word and returns to IDLE. The next frame needs a fresh falling edge.
// TESTING
//  cpb=16, no parity, send 0xA5 (8N1), rx_ready=1 -> rx_data=0xA5 for exactly 1 cycle.
//   rx_valid must rise 2+8+16*9+1 cycles after the start edge. perr=ferr=0.
//  parity_en=1, send 0x3C with parity bit 1 (wrong for even) -> rx_data=0x3C, parity_err=1, frame_err=0.
//   Repeat with parity bit 0 -> parity_err=0.
//  Send 0x55 with stop bit 0 -> frame_err=1. Hold the line low for 100 cycles -> no second frame.
//  Drive rx low for 3 cycles with cpb=16 -> START rejects it. No rx_valid, rx_busy back to 0.
//  rx_ready=0, send 0x11 then 0x22 -> rx_data stays 0x11 and overrun pulses once.
//   Then raise rx_ready -> 0x11 is accepted and rx_valid falls.
//  cpb=16, brr_valid with 32 at bit 3 -> frame decodes at 16. Reset during bit 4 -> outputs 0, IDLE.
//   The next 0x0F frame sent at cpb=32 decodes correctly.

Source files
------------

// File: rtl/uart_rx_core.sv
// uart_rx_core: UART receive datapath.
//   Samples the asynchronous rx line through a 2-flop synchronizer, decodes
//   start / DATA_W data bits (LSB first) / optional parity / stop, and presents
//   the word in a holding register drained through a valid/ready handshake.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   rx                       serial input, idle high
//   brr_valid, clk_per_bit   strobe + clocks-per-bit (values < 4 clamp to 4)
//   ctrl_valid, parity_en    strobe + parity enable
//   rx_data, parity_err,
//   frame_err, rx_valid      held word and status
//   rx_ready                 consumer accept
//   overrun                  1-cycle pulse when a completed frame is dropped
//   rx_busy                  receiver not idle
module uart_rx_core #(
  parameter int          DATA_W      = 8,
  parameter logic [15:0] DEFAULT_CPB = 16'd868,
  parameter bit          PARITY_ODD  = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx,
  input  logic              brr_valid,
  input  logic [15:0]       clk_per_bit,
  input  logic              ctrl_valid,
  input  logic              parity_en,
  output logic [DATA_W-1:0] rx_data,
  output logic              parity_err,
  output logic              frame_err,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              overrun,
  output logic              rx_busy
);

  localparam int IW = $clog2(DATA_W + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t            state, state_nxt;
  logic              rx_m, rx_s, rx_s_d;
  logic [15:0]       cfg_cpb, cpb_act, cnt;
  logic              cfg_par, par_act;
  logic [IW-1:0]     bit_idx;
  logic [DATA_W-1:0] shift;
  logic              perr;

  logic sample, start_det, last_bit, commit;

  assign sample    = (cnt == '0);
  assign start_det = rx_s_d & ~rx_s;
  assign last_bit  = (bit_idx == IW'(DATA_W - 1));
  assign rx_busy   = (state != S_IDLE);

  always_comb begin
    state_nxt = state;
    commit    = 1'b0;
    case (state)
      S_IDLE:   if (start_det) state_nxt = S_START;
      S_START:  if (sample) state_nxt = rx_s ? S_IDLE : S_DATA;
      S_DATA:   if (sample && last_bit) state_nxt = par_act ? S_PARITY : S_STOP;
      S_PARITY: if (sample) state_nxt = S_STOP;
      S_STOP: begin
        if (sample) begin
          state_nxt = S_IDLE;
          commit    = 1'b1;
        end
      end
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      rx_m       <= 1'b1;
      rx_s       <= 1'b1;
      rx_s_d     <= 1'b1;
      cfg_cpb    <= DEFAULT_CPB;
      cfg_par    <= 1'b0;
      cpb_act    <= DEFAULT_CPB;
      par_act    <= 1'b0;
      cnt        <= '0;
      bit_idx    <= '0;
      shift      <= '0;
      perr       <= 1'b0;
      rx_data    <= '0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      rx_valid   <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      rx_m   <= rx;
      rx_s   <= rx_m;
      rx_s_d <= rx_s;
      state  <= state_nxt;

      if (brr_valid) cfg_cpb <= (clk_per_bit < 16'd4) ? 16'd4 : clk_per_bit;
      if (ctrl_valid) cfg_par <= parity_en;

      // Frame config is latched at the start edge; the half-bit load uses the
      // live register because cpb_act is only being written this same cycle.
      if (state == S_IDLE) begin
        if (start_det) begin
          cpb_act <= cfg_cpb;
          par_act <= cfg_par;
          cnt     <= cfg_cpb >> 1;
          perr    <= 1'b0;
        end
      end else if (sample) begin
        cnt <= cpb_act - 16'd1;
      end else begin
        cnt <= cnt - 16'd1;
      end

      if (sample) begin
        case (state)
          S_START:  bit_idx <= '0;
          S_DATA: begin
            shift   <= {rx_s, shift[DATA_W-1:1]};
            bit_idx <= bit_idx + IW'(1);
          end
          S_PARITY: perr <= ^shift ^ rx_s ^ PARITY_ODD;
          default: ;
        endcase
      end

      overrun <= 1'b0;
      if (commit && (!rx_valid || rx_ready)) begin
        rx_data    <= shift;
        parity_err <= perr;
        frame_err  <= ~rx_s;
        rx_valid   <= 1'b1;
      end else if (commit) begin
        overrun <= 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_core.sv
// tb_uart_rx_core: randomized self-checking bench for uart_rx_core.
//   Frames are serialized by tasks; each frame that should reach the consumer
//   pushes its expected word/status into a queue, and a negedge monitor pops and
//   compares on every accepted handshake.
module tb_uart_rx_core;

  localparam bit PODD = 1'b0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx = 1'b1;
  logic        brr_valid = 1'b0;
  logic [15:0] clk_per_bit = '0;
  logic        ctrl_valid = 1'b0;
  logic        parity_en = 1'b0;
  logic [7:0]  rx_data;
  logic        parity_err, frame_err, rx_valid, overrun, rx_busy;
  logic        rx_ready = 1'b1;

  uart_rx_core #(
    .DATA_W      (8),
    .DEFAULT_CPB (16'd868),
    .PARITY_ODD  (PODD)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rx          (rx),
    .brr_valid   (brr_valid),
    .clk_per_bit (clk_per_bit),
    .ctrl_valid  (ctrl_valid),
    .parity_en   (parity_en),
    .rx_data     (rx_data),
    .parity_err  (parity_err),
    .frame_err   (frame_err),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .overrun     (overrun),
    .rx_busy     (rx_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    bit         pe;
    bit         fe;
  } exp_t;

  exp_t q[$];
  int   passed = 0;
  int   total  = 0;
  int   ov_cnt = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Scoreboard monitor: every accepted word must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && rx_valid && rx_ready) begin
      if (q.size() == 0) begin
        total++;
        $display("FAIL unexpected_word: got 0x%02h expected none", rx_data);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("rx_data", int'(rx_data), int'(e.d));
        check("parity_err", int'(parity_err), int'(e.pe));
        check("frame_err", int'(frame_err), int'(e.fe));
      end
    end
    if (!rst && overrun) ov_cnt++;
  end

  // All drive tasks start and end 1 time unit after a rising edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    tick(n);
  endtask

  task automatic set_cpb(input int v);
    clk_per_bit = 16'(v);
    brr_valid   = 1'b1;
    tick(1);
    brr_valid   = 1'b0;
  endtask

  task automatic set_par(input bit v);
    parity_en  = v;
    ctrl_valid = 1'b1;
    tick(1);
    ctrl_valid = 1'b0;
  endtask

  task automatic drive_bit(input bit b, input int cpb);
    rx = b;
    tick(cpb);
  endtask

  // Reference: parity error when the ones count over data+parity bit disagrees
  // with the selected parity sense; frame error when the stop bit is low.
  task automatic send_frame(input logic [7:0] d, input int cpb, input bit pe,
                            input bit pbit, input bit stopb, input bit keep);
    exp_t e;
    int   ones;
    if (keep) begin
      ones = 0;
      for (int i = 0; i < 8; i++) ones += int'(d[i]);
      ones += int'(pbit);
      e.d  = d;
      e.pe = pe ? (((ones % 2) == 1) != PODD) : 1'b0;
      e.fe = !stopb;
      q.push_back(e);
    end
    drive_bit(1'b0, cpb);
    for (int i = 0; i < 8; i++) drive_bit(d[i], cpb);
    if (pe) drive_bit(pbit, cpb);
    drive_bit(stopb, cpb);
  endtask

  initial begin
    int lat;

    tick(5);
    rst = 1'b0;
    @(negedge clk);
    check("rst_rx_data", int'(rx_data), 0);
    check("rst_rx_valid", int'(rx_valid), 0);
    check("rst_parity_err", int'(parity_err), 0);
    check("rst_frame_err", int'(frame_err), 0);
    check("rst_overrun", int'(overrun), 0);
    check("rst_rx_busy", int'(rx_busy), 0);
    tick(1);

    // 8N1 at 16 clocks/bit; latency counted in rising edges after the line
    // drop. Edge 1 first sees the low level, so the word appears 155 edges
    // later (2 sync + 8 half-bit + 9*16 + 1 commit).
    set_cpb(16);
    idle(4);
    lat = 0;
    fork
      send_frame(8'hA5, 16, 1'b0, 1'b0, 1'b1, 1'b1);
      begin
        for (int n = 1; n <= 400; n++) begin
          @(posedge clk);
          #1;
          if (rx_valid) begin
            lat = n;
            break;
          end
        end
      end
    join
    check("latency", lat, 1 + 2 + 8 + 16 * 9 + 1);
    idle(4);

    // Parity: wrong even parity bit, then correct one.
    set_par(1'b1);
    send_frame(8'h3C, 16, 1'b1, 1'b1, 1'b1, 1'b1);
    idle(4);
    send_frame(8'h3C, 16, 1'b1, 1'b0, 1'b1, 1'b1);
    idle(4);
    set_par(1'b0);

    // Framing error, then a long low line that must not retrigger.
    send_frame(8'h55, 16, 1'b0, 1'b0, 1'b0, 1'b1);
    rx = 1'b0;
    tick(100);
    @(negedge clk);
    check("hold_low_busy", int'(rx_busy), 0);
    tick(1);
    idle(20);

    // Short glitch: enters START then rejects it.
    rx = 1'b0;
    tick(3);
    rx = 1'b1;
    tick(2);
    @(negedge clk);
    check("glitch_busy_high", int'(rx_busy), 1);
    tick(30);
    @(negedge clk);
    check("glitch_busy_low", int'(rx_busy), 0);
    check("glitch_no_valid", int'(rx_valid), 0);
    tick(1);

    // Overrun: second frame dropped while the first is held.
    rx_ready = 1'b0;
    send_frame(8'h11, 16, 1'b0, 1'b0, 1'b1, 1'b1);
    send_frame(8'h22, 16, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(4);
    @(negedge clk);
    check("held_valid", int'(rx_valid), 1);
    check("held_data", int'(rx_data), 8'h11);
    check("overrun_once", ov_cnt, 1);
    tick(1);
    rx_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("valid_dropped", int'(rx_valid), 0);
    tick(1);

    // Randomized frames: data, parity mode/bit, stop bit, clocks-per-bit
    // (requests below 4 are clamped to 4 by the receiver).
    for (int k = 0; k < 20; k++) begin
      int req, eff;
      bit pe;
      req = $urandom_range(1, 40);
      eff = (req < 4) ? 4 : req;
      pe  = 1'($urandom_range(0, 1));
      set_cpb(req);
      set_par(pe);
      idle(2);
      send_frame(8'($urandom), eff, pe, 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 3) != 0), 1'b1);
      idle(2 * eff);
    end
    set_par(1'b0);
    set_cpb(16);
    idle(4);

    // Rate change mid-frame only applies to the next frame.
    fork
      send_frame(8'h96, 16, 1'b0, 1'b0, 1'b1, 1'b1);
      begin
        tick(16 * 4 + 8);
        clk_per_bit = 16'd32;
        brr_valid   = 1'b1;
        tick(1);
        brr_valid   = 1'b0;
      end
    join
    idle(4);

    // Held word then reset during a later frame: both cleared.
    rx_ready = 1'b0;
    send_frame(8'h77, 32, 1'b0, 1'b0, 1'b1, 1'b1);
    idle(4);
    fork
      send_frame(8'hC3, 32, 1'b0, 1'b0, 1'b1, 1'b0);
      begin
        tick(32 * 5 + 16);
        rst = 1'b1;
      end
    join
    q.delete();
    @(negedge clk);
    check("midrst_rx_valid", int'(rx_valid), 0);
    check("midrst_rx_data", int'(rx_data), 0);
    check("midrst_rx_busy", int'(rx_busy), 0);
    tick(1);
    rst = 1'b0;
    rx_ready = 1'b1;
    idle(4);
    set_cpb(32);
    idle(4);
    send_frame(8'h0F, 32, 1'b0, 1'b0, 1'b1, 1'b1);
    idle(8);

    check("pending_words", q.size(), 0);
    check("overrun_total", ov_cnt, 1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
